sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It generalises the team's 32x32 synchronous FIFO with the following additions:
- configurable data width and depth (depth need not be a power of two)
- selectable standard or first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- occupancy output
- sticky overflow and underflow error flags
- synchronous flush

It sits between single-clock producer/consumer datapath stages.

---
 rtl/sync_fifo_pkg.sv | 22 ++
 rtl/sync_fifo_ram.sv | 25 ++
 rtl/sync_fifo_param.sv | 116 +++++++++++
 tb/tb_sync_fifo_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - read-mode type, width helpers and wrapping pointer increment
package sync_fifo_pkg;

  typedef enum logic {RD_STANDARD = 1'b0, RD_FWFT = 1'b1} rd_mode_e;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_DEPTH  = 32;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// rtl/sync_fifo_ram.sv - DATA_W x DEPTH storage, synchronous write, asynchronous read
module sync_fifo_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with FWFT option, thresholds and sticky errors
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = DEFAULT_DATA_W,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned AFULL_THR  = DEPTH - 2,
  parameter int unsigned AEMPTY_THR = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                           clk,
  input  logic                           reset_signal,
  input  logic                           flush,
  input  logic                           write_enable,
  input  logic [DATA_W-1:0]              data_input,
  input  logic                           read_enable,
  output logic [DATA_W-1:0]              data_output,
  output logic                           full_f,
  output logic                           empty_f,
  output logic                           almost_full_f,
  output logic                           almost_empty_f,
  output logic [level_width(DEPTH)-1:0]  level,
  output logic                           overflow_f,
  output logic                           underflow_f,
  input  logic                           clear_errors
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);
  localparam rd_mode_e    MODE  = (FWFT != 0) ? RD_FWFT : RD_STANDARD;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_THR);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_THR);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] dout_q, dout_d, ram_rdata;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              wr_acc, rd_acc;

  assign full_f         = (level_q == DEPTH_L);
  assign empty_f        = (level_q == '0);
  assign almost_full_f  = (level_q >= AFULL_L);
  assign almost_empty_f = (level_q <= AEMPTY_L);
  assign level          = level_q;
  assign overflow_f     = ovf_q;
  assign underflow_f    = unf_q;

  // Flush swallows both requests outright, including their error side effects.
  assign wr_acc = write_enable & ~full_f & ~flush;
  assign rd_acc = read_enable & ~empty_f & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      dout_d   = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      end
      if (rd_acc) begin
        rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
        dout_d   = ram_rdata;
      end
      if (wr_acc && !rd_acc) begin
        level_d = level_q + LVL_W'(1);
      end else if (rd_acc && !wr_acc) begin
        level_d = level_q - LVL_W'(1);
      end
    end
    // A new error outranks a clear in the same cycle.
    ovf_d = (write_enable & full_f & ~flush) | (ovf_q & ~clear_errors);
    unf_d = (read_enable & empty_f & ~flush) | (unf_q & ~clear_errors);
  end

  always_ff @(posedge clk or negedge reset_signal) begin
    if (!reset_signal) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_input),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (ram_rdata)
  );

  assign data_output = (MODE == RD_FWFT) ? (empty_f ? '0 : ram_rdata) : dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - three FIFO configurations on shared stimulus, checked against a queue model
module tb_sync_fifo_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_signal, flush, write_enable, read_enable, clear_errors;
  logic [31:0] data_input;
  logic [31:0] dout [3];
  logic        full_o [3], empty_o [3], af_o [3], ae_o [3], ovf_o [3], unf_o [3];
  logic [5:0]  lvl0;
  logic [2:0]  lvl1, lvl2;

  int checks = 0;
  int errors = 0;

  // Configurations: 0 = 32 deep standard, 1 = 5 deep standard, 2 = 6 deep FWFT
  int unsigned m_depth [3] = '{32, 5, 6};
  int unsigned m_af    [3] = '{30, 4, 6};
  int unsigned m_ae    [3] = '{2, 1, 0};
  bit          m_fwft  [3] = '{1'b0, 1'b0, 1'b1};

  logic [31:0] mq [3][$];
  logic        m_ovf [3], m_unf [3];
  logic [31:0] m_dout [3];

  sync_fifo_param u_dut0 (
    .clk(clk), .reset_signal(reset_signal), .flush(flush),
    .write_enable(write_enable), .data_input(data_input), .read_enable(read_enable),
    .data_output(dout[0]), .full_f(full_o[0]), .empty_f(empty_o[0]),
    .almost_full_f(af_o[0]), .almost_empty_f(ae_o[0]), .level(lvl0),
    .overflow_f(ovf_o[0]), .underflow_f(unf_o[0]), .clear_errors(clear_errors)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(5), .AFULL_THR(4), .AEMPTY_THR(1), .FWFT(0)) u_dut1 (
    .clk(clk), .reset_signal(reset_signal), .flush(flush),
    .write_enable(write_enable), .data_input(data_input), .read_enable(read_enable),
    .data_output(dout[1]), .full_f(full_o[1]), .empty_f(empty_o[1]),
    .almost_full_f(af_o[1]), .almost_empty_f(ae_o[1]), .level(lvl1),
    .overflow_f(ovf_o[1]), .underflow_f(unf_o[1]), .clear_errors(clear_errors)
  );

  sync_fifo_param #(.DATA_W(32), .DEPTH(6), .AFULL_THR(6), .AEMPTY_THR(0), .FWFT(1)) u_dut2 (
    .clk(clk), .reset_signal(reset_signal), .flush(flush),
    .write_enable(write_enable), .data_input(data_input), .read_enable(read_enable),
    .data_output(dout[2]), .full_f(full_o[2]), .empty_f(empty_o[2]),
    .almost_full_f(af_o[2]), .almost_empty_f(ae_o[2]), .level(lvl2),
    .overflow_f(ovf_o[2]), .underflow_f(unf_o[2]), .clear_errors(clear_errors)
  );

  typedef struct {
    logic        we, re, fl, clr;
    logic [31:0] din;
    int          lvl;
    logic        full, empty, af, ae, ovf, unf;
    logic [31:0] dout;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mkv(input logic we, input logic re, input logic fl, input logic clr,
                               input logic [31:0] din, input int lvl, input logic ovf,
                               input logic unf, input logic [31:0] dout_e);
    vec_t v;
    v.we = we; v.re = re; v.fl = fl; v.clr = clr; v.din = din;
    v.lvl = lvl; v.ovf = ovf; v.unf = unf; v.dout = dout_e;
    v.full  = (lvl == 32);
    v.empty = (lvl == 0);
    v.af    = (lvl >= 30);
    v.ae    = (lvl <= 2);
    return v;
  endfunction

  function automatic int got_lvl(input int i);
    case (i)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_ovf[i]  = 1'b0;
      m_unf[i]  = 1'b0;
      m_dout[i] = '0;
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  is_full, is_empty;
    for (int i = 0; i < 3; i++) begin
      sz       = mq[i].size();
      is_full  = (sz == int'(m_depth[i]));
      is_empty = (sz == 0);
      m_ovf[i] = (m_ovf[i] & ~clear_errors) | (write_enable & is_full & ~flush);
      m_unf[i] = (m_unf[i] & ~clear_errors) | (read_enable & is_empty & ~flush);
      if (flush) begin
        mq[i].delete();
        m_dout[i] = '0;
      end else begin
        if (read_enable && !is_empty) m_dout[i] = mq[i].pop_front();
        if (write_enable && !is_full) mq[i].push_back(data_input);
      end
    end
  endtask

  task automatic check_model();
    int          sz;
    logic [31:0] exp_dout;
    for (int i = 0; i < 3; i++) begin
      sz = mq[i].size();
      if (m_fwft[i]) exp_dout = (sz == 0) ? 32'h0 : mq[i][0];
      else           exp_dout = m_dout[i];
      chk("m_level", i, 32'(got_lvl(i)), 32'(sz));
      chk("m_full",  i, 32'(full_o[i]),  32'(sz == int'(m_depth[i])));
      chk("m_empty", i, 32'(empty_o[i]), 32'(sz == 0));
      chk("m_afull", i, 32'(af_o[i]),    32'(sz >= int'(m_af[i])));
      chk("m_aempty",i, 32'(ae_o[i]),    32'(sz <= int'(m_ae[i])));
      chk("m_ovf",   i, 32'(ovf_o[i]),   32'(m_ovf[i]));
      chk("m_unf",   i, 32'(unf_o[i]),   32'(m_unf[i]));
      chk("m_dout",  i, dout[i],         exp_dout);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic fl, input logic clr,
                      input logic [31:0] din);
    write_enable = we; read_enable = re; flush = fl; clear_errors = clr; data_input = din;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_signal = 1'b0; flush = 1'b0; write_enable = 1'b0; read_enable = 1'b0;
    clear_errors = 1'b0; data_input = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model();
    chk("rst_dout0", 0, dout[0], 32'h0);
    reset_signal = 1'b1;

    // Directed table for the 32-deep standard instance
    for (int i = 1; i <= 32; i++) vt.push_back(mkv(1, 0, 0, 0, 32'(i), i, 0, 0, 32'h0));
    vt.push_back(mkv(1, 0, 0, 0, 32'hFF, 32, 1, 0, 32'h0));
    for (int i = 1; i <= 32; i++) vt.push_back(mkv(0, 1, 0, 0, 32'h0, 32 - i, 1, 0, 32'(i)));
    vt.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 0, 32'h20));
    vt.push_back(mkv(1, 1, 0, 0, 32'h77, 1, 0, 1, 32'h20));
    vt.push_back(mkv(1, 0, 0, 0, 32'h78, 2, 0, 1, 32'h20));
    vt.push_back(mkv(1, 0, 0, 0, 32'h79, 3, 0, 1, 32'h20));
    vt.push_back(mkv(1, 1, 0, 0, 32'h7A, 3, 0, 1, 32'h77));
    vt.push_back(mkv(0, 0, 1, 1, 32'h0, 0, 0, 0, 32'h0));
    for (int i = 1; i <= 32; i++) vt.push_back(mkv(1, 0, 0, 0, 32'h100 + 32'(i), i, 0, 0, 32'h0));
    vt.push_back(mkv(1, 1, 0, 0, 32'hDEAD, 31, 1, 0, 32'h101));
    for (int k = 1; k <= 21; k++) vt.push_back(mkv(0, 1, 0, 0, 32'h0, 31 - k, 1, 0, 32'h101 + 32'(k)));
    vt.push_back(mkv(1, 0, 1, 0, 32'hBAD, 0, 1, 0, 32'h0));
    vt.push_back(mkv(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0));
    vt.push_back(mkv(0, 1, 0, 0, 32'h0, 0, 1, 1, 32'h0));
    vt.push_back(mkv(0, 0, 0, 1, 32'h0, 0, 0, 0, 32'h0));

    for (int k = 0; k < vt.size(); k++) begin
      step(vt[k].we, vt[k].re, vt[k].fl, vt[k].clr, vt[k].din);
      chk("t_level",  k, 32'(lvl0),       32'(vt[k].lvl));
      chk("t_full",   k, 32'(full_o[0]),  32'(vt[k].full));
      chk("t_empty",  k, 32'(empty_o[0]), 32'(vt[k].empty));
      chk("t_afull",  k, 32'(af_o[0]),    32'(vt[k].af));
      chk("t_aempty", k, 32'(ae_o[0]),    32'(vt[k].ae));
      chk("t_ovf",    k, 32'(ovf_o[0]),   32'(vt[k].ovf));
      chk("t_unf",    k, 32'(unf_o[0]),   32'(vt[k].unf));
      chk("t_dout",   k, dout[0],         vt[k].dout);
    end

    // Depth-5 wrap with occupancy held at two
    step(0, 0, 1, 1, 32'h0);
    step(1, 0, 0, 0, 32'h500);
    step(1, 0, 0, 0, 32'h501);
    for (int k = 0; k < 13; k++) begin
      step(1, 1, 0, 0, 32'h502 + 32'(k));
      chk("w5_level", k, 32'(lvl1),     32'd2);
      chk("w5_dout",  k, dout[1],       32'h500 + 32'(k));
      chk("w5_ovf",   k, 32'(ovf_o[1]), 32'd0);
      chk("w5_unf",   k, 32'(unf_o[1]), 32'd0);
    end

    // FWFT visibility, underflow and clear-vs-set priority
    step(0, 0, 1, 1, 32'h0);
    step(1, 0, 0, 0, 32'hA5);
    chk("fw_dout",  0, dout[2], 32'hA5);
    chk("fw_empty", 0, 32'(empty_o[2]), 32'd0);
    step(0, 1, 0, 0, 32'h0);
    chk("fw_empty", 1, 32'(empty_o[2]), 32'd1);
    chk("fw_dout",  1, dout[2], 32'h0);
    step(0, 1, 0, 0, 32'h0);
    chk("fw_unf", 0, 32'(unf_o[2]), 32'd1);
    step(0, 0, 0, 1, 32'h0);
    chk("fw_unf", 1, 32'(unf_o[2]), 32'd0);
    step(0, 1, 0, 1, 32'h0);
    chk("fw_unf", 2, 32'(unf_o[2]), 32'd1);

    // Randomised traffic with an asynchronous reset in the middle
    for (int k = 0; k < 400; k++) begin
      logic we, re, fl, clr;
      we  = ($urandom_range(0, 99) < ((k % 100) < 50 ? 70 : 35));
      re  = ($urandom_range(0, 99) < ((k % 100) < 50 ? 35 : 70));
      fl  = ($urandom_range(0, 31) == 0);
      clr = ($urandom_range(0, 15) == 0);
      step(we, re, fl, clr, $urandom);
      if (k == 200) begin
        #2;
        reset_signal = 1'b0;
        #1;
        model_reset();
        check_model();
        chk("ar_dout0", 0, dout[0], 32'h0);
        chk("ar_lvl0",  0, 32'(lvl0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_model();
        reset_signal = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
